// File: rtl/ifid_skid_stage.sv
// ----------------------------------------------------------------------------
// ifid_skid_stage
//   IF/ID pipeline register built as a 2-entry skid buffer (head + skid).
//   Fetch pushes instructions through a valid/ready handshake. Decode sees the
//   head entry split into MIPS fields, along with a pc+4 that is precomputed
//   when the entry is captured. A flush (taken branch or jump) empties the
//   stage.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready input handshake; in_ready depends on state only
//   in_instr, in_pc   fetched instruction word and its address
//   flush             drop held entries and ignore the incoming one
//   out_valid/out_ready output handshake towards decode
//   opcode..imm16     slices of the head instruction
//   pc_plus4          stored head pc + 4 (wraps modulo 2^32)
//   instr_count       retired output handshakes
//
// Configuration
//   IFID_PERF_CNT_EN  when defined, instr_count is a wrapping 32-bit counter
//                     of non-flushed output handshakes. When undefined, the
//                     port is tied to 0 and no counter flops are built.
// ----------------------------------------------------------------------------
module ifid_skid_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] head_pc4_q,   head_pc4_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q,   skid_pc4_d;

    logic        in_hs;
    logic        out_hs;
    logic [31:0] in_pc4;

    // Both ready and valid decode from the registered state. Because of this,
    // no combinational path runs from out_ready back to in_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);

    assign in_hs  = in_valid  & in_ready;
    assign out_hs = out_valid & out_ready;
    assign in_pc4 = in_pc + 32'd4;

    always_comb begin
        state_d      = state_q;
        head_instr_d = head_instr_q;
        head_pc4_d   = head_pc4_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;

        if (flush) begin
            // Stored contents are kept, so the field outputs hold the last
            // head value while the stage is empty.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_hs) begin
                        state_d      = ONE;
                        head_instr_d = in_instr;
                        head_pc4_d   = in_pc4;
                    end
                end
                ONE: begin
                    if (in_hs && out_hs) begin
                        head_instr_d = in_instr;
                        head_pc4_d   = in_pc4;
                    end else if (in_hs) begin
                        // Head is stalled, so the new entry parks in skid.
                        state_d      = FULL;
                        skid_instr_d = in_instr;
                        skid_pc4_d   = in_pc4;
                    end else if (out_hs) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_hs) begin
                        state_d      = ONE;
                        head_instr_d = skid_instr_q;
                        head_pc4_d   = skid_pc4_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            head_instr_q <= '0;
            head_pc4_q   <= '0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            head_instr_q <= head_instr_d;
            head_pc4_q   <= head_pc4_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign opcode   = head_instr_q[31:26];
    assign rs       = head_instr_q[25:21];
    assign rt       = head_instr_q[20:16];
    assign rd       = head_instr_q[15:11];
    assign shamt    = head_instr_q[10:6];
    assign funct    = head_instr_q[5:0];
    assign imm16    = head_instr_q[15:0];
    assign pc_plus4 = head_pc4_q;

`ifdef IFID_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // A handshake that coincides with a flush does not count as retired.
    assign cnt_d = (out_hs && !flush) ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_ifid_skid_stage.sv
module tb_ifid_skid_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [31:0] pc_plus4;
    logic [31:0] instr_count;

    int n_chk = 0;
    int n_err = 0;

    ifid_skid_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .imm16      (imm16),
        .pc_plus4   (pc_plus4),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    function automatic logic [31:0] head_word();
        return {opcode, rs, rt, rd, shamt, funct};
    endfunction

    localparam logic [31:0] I_A = 32'h8C43_0010;
    localparam logic [31:0] I_B = 32'h0043_2020;
    localparam logic [31:0] I_C = 32'h1000_FFFF;
    localparam logic [31:0] I_D = 32'hAC85_0004;
    localparam logic [31:0] I_E = 32'h0800_1234;
    localparam logic [31:0] I_F = 32'h2402_0007;
    localparam logic [31:0] I_G = 32'h3C01_ABCD;
    localparam logic [31:0] I_H = 32'h0000_0008;

    logic [31:0] exp_cnt;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_head",      head_word(),        32'd0);
        chk("rst_pc4",       pc_plus4,           32'd0);
        chk("rst_cnt",       instr_count,        32'd0);
        #11 rst_n = 1'b1;   // released between edges

        // Single instruction, one-cycle latency, field decode
        drive(1'b1, 32'h2128_FFFC, 32'h0040_0000, 1'b1, 1'b0);
        tick();
        chk("t1_valid",  {31'd0, out_valid}, 32'd1);
        chk("t1_opcode", {26'd0, opcode}, 32'h08);
        chk("t1_rs",     {27'd0, rs},     32'd9);
        chk("t1_rt",     {27'd0, rt},     32'd8);
        chk("t1_rd",     {27'd0, rd},     32'd31);
        chk("t1_shamt",  {27'd0, shamt},  32'd31);
        chk("t1_funct",  {26'd0, funct},  32'h3C);
        chk("t1_imm16",  {16'd0, imm16},  32'h0000_FFFC);
        chk("t1_pc4",    pc_plus4,        32'h0040_0004);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();   // drained -> EMPTY, fields hold
        chk("t1_empty",  {31'd0, out_valid}, 32'd0);
        chk("t1_hold",   {26'd0, opcode},    32'h08);

        // Backpressure: A, B fill the stage, C is stalled
        drive(1'b1, I_A, 32'h0000_0100, 1'b0, 1'b0);
        tick();
        chk("t2_one_rdy", {31'd0, in_ready}, 32'd1);
        chk("t2_head_A",  head_word(),       I_A);
        drive(1'b1, I_B, 32'h0000_0104, 1'b0, 1'b0);
        tick();
        chk("t2_full_rdy", {31'd0, in_ready}, 32'd0);
        chk("t2_head_A2",  head_word(),       I_A);
        drive(1'b1, I_C, 32'h0000_0108, 1'b0, 1'b0);
        tick();
        chk("t2_stall_rdy", {31'd0, in_ready}, 32'd0);
        chk("t2_head_A3",   head_word(),       I_A);
        chk("t2_pc4_A",     pc_plus4,          32'h0000_0104);
        drive(1'b1, I_C, 32'h0000_0108, 1'b1, 1'b0);
        tick();   // A retired, B to head
        chk("t2_head_B", head_word(), I_B);
        chk("t2_pc4_B",  pc_plus4,    32'h0000_0108);
        chk("t2_rdy_B",  {31'd0, in_ready}, 32'd1);
        tick();   // B retired, C accepted into head
        chk("t2_head_C", head_word(), I_C);
        chk("t2_pc4_C",  pc_plus4,    32'h0000_010C);
        chk("t2_vld_C",  {31'd0, out_valid}, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();   // C retired
        chk("t2_drained", {31'd0, out_valid}, 32'd0);

        // Flush while FULL with a simultaneous push and out_ready
        drive(1'b1, I_D, 32'h0000_0200, 1'b0, 1'b0);
        tick();
        drive(1'b1, I_E, 32'h0000_0204, 1'b0, 1'b0);
        tick();
        chk("t3_full", {31'd0, in_ready}, 32'd0);
        drive(1'b1, I_F, 32'h0000_0208, 1'b1, 1'b1);
        tick();
        chk("t3_fl_valid", {31'd0, out_valid}, 32'd0);
        chk("t3_fl_ready", {31'd0, in_ready},  32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("t3_post_valid", {31'd0, out_valid}, 32'd0);

        // pc wraparound
        drive(1'b1, I_G, 32'hFFFF_FFFC, 1'b1, 1'b0);
        tick();
        chk("t4_head_G", head_word(), I_G);
        chk("t4_pc4_wrap", pc_plus4, 32'h0000_0000);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();   // G retired: 5 handshakes total (1 + A,B,C + G)
`ifdef IFID_PERF_CNT_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        chk("t4_count", instr_count, exp_cnt);

        // Asynchronous reset mid-cycle while FULL
        drive(1'b1, I_A, 32'h0000_0300, 1'b0, 1'b0);
        tick();
        drive(1'b1, I_B, 32'h0000_0304, 1'b0, 1'b0);
        tick();
        chk("t5_full", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_arst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_arst_ready", {31'd0, in_ready},  32'd1);
        chk("t5_arst_head",  head_word(),        32'd0);
        chk("t5_arst_pc4",   pc_plus4,           32'd0);
        chk("t5_arst_cnt",   instr_count,        32'd0);
        #2 rst_n = 1'b1;

        // First edge after reset accepts
        drive(1'b1, I_H, 32'h0000_0400, 1'b0, 1'b0);
        tick();
        chk("t6_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_head",  head_word(),        I_H);
        chk("t6_pc4",   pc_plus4,           32'h0000_0404);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ifid_skid_stage.md
IFID_SKID_STAGE -- requirements
Module: ifid_skid_stage

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 The block SHALL have these ports, one per line as name  direction  width  meaning:
  clk  input  1  sole clock, rising edge.
  rst_n  input  1  asynchronous active-low reset.
  in_valid  input  1  fetch presents an instruction.
  in_ready  output  1  stage accepts an instruction this cycle.
  in_instr  input  32  fetched MIPS instruction word.
  in_pc  input  32  address of in_instr.
  flush  input  1  discard all held and incoming instructions (branch/jump taken).
  out_valid  output  1  decoded entry available to the decode stage.
  out_ready  input  1  decode stage consumes the entry this cycle.
  opcode  output  6  instr[31:26] of the head entry.
  rs  output  5  instr[25:21].
  rt  output  5  instr[20:16].
  rd  output  5  instr[15:11].
  shamt  output  5  instr[10:6].
  funct  output  6  instr[5:0].
  imm16  output  16  instr[15:0], fed to the sign extender.
  pc_plus4  output  32  head entry in_pc + 4, modulo 2^32.
  instr_count  output  32  count of retired handshakes (see Configuration).

Function
REQ-003 Input handshake SHALL occur on a rising edge with in_valid=1 and in_ready=1; output handshake on a rising edge with out_valid=1 and out_ready=1.
REQ-004 Storage SHALL be a 2-entry skid buffer (head register plus skid register), FSM states EMPTY, ONE, FULL.
REQ-005 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, driven from state only (no combinational path from out_ready).
REQ-006 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-007 Transitions without flush: EMPTY + input hs -> ONE; ONE + input hs only -> FULL (entry to skid); ONE + output hs only -> EMPTY; ONE + both -> ONE (new entry to head); FULL + output hs -> ONE (skid moves to head); otherwise hold.
REQ-008 Ordering SHALL be strict FIFO; no entry is duplicated or dropped except by flush.
REQ-009 All field outputs SHALL be slices of the head register, valid whenever out_valid=1; when out_valid=0 they hold the last head contents.
REQ-010 Latency SHALL be one cycle: an instruction accepted at edge N appears at outputs after edge N when the stage was EMPTY.
REQ-011 pc_plus4 SHALL be computed at capture time and stored; 0xFFFFFFFC SHALL yield 0x00000000.
REQ-012 flush=1 at an edge SHALL force state EMPTY, ignore any simultaneous input handshake, and count no output handshake; in_ready remains per state during the flush cycle.
REQ-013 flush SHALL take priority over all simultaneous events.

Reset
REQ-014 While rst_n=0: state EMPTY, out_valid=0, in_ready=1, head and skid registers 0 (all field outputs 0, pc_plus4 0), instr_count 0.
REQ-015 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-016 After rst_n rises, the first edge SHALL be able to accept an input.

Configuration
REQ-017 Macro IFID_PERF_CNT_EN SHALL control the instruction counter.
REQ-018 With IFID_PERF_CNT_EN defined: instr_count increments by 1 on each non-flushed output handshake, wrapping 0xFFFFFFFF -> 0; flush does not clear it.
REQ-019 Without IFID_PERF_CNT_EN: instr_count port SHALL exist and be constant 0; no counter flops.

Verification
REQ-020 Reset then in_instr=0x2128FFFC, in_pc=0x00400000, out_ready=1 -> next cycle out_valid=1, opcode=0x08, rs=9, rt=8, imm16=0xFFFC, pc_plus4=0x00400004.
REQ-021 out_ready=0, push three instructions A,B,C -> A,B accepted, in_ready=0 during C; release out_ready -> A,B,C drained in order, none lost.
REQ-022 State FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; pending entries never appear at output.
REQ-023 in_pc=0xFFFFFFFC -> pc_plus4=0x00000000.
REQ-024 rst_n pulsed low between edges while FULL -> out_valid=0 immediately, fields 0.
REQ-025 IFID_PERF_CNT_EN defined, 5 output handshakes plus one flushed cycle -> instr_count=5; undefined -> instr_count=0 throughout.
